// File: rtl/digit_serial_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addsub_pkg
// Brief    : Shared constants and FSM state type for the digit-serial add/sub.
// Revision : 1.0 - initial release
// ============================================================================
package addsub_pkg;

    localparam int c_DIGIT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/digit_serial_addsub_if.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_addsub_if
// Brief    : Operand/result handshake bundle for digit_serial_addsub.
// Revision : 1.0 - initial release
// ============================================================================
interface digit_serial_addsub_if #(
    parameter int WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             CoBo;
    logic             busy;

    // Operand source / result consumer side
    modport master (
        output in_valid, a, b, m, out_ready,
        input  in_ready, out_valid, S, CoBo, busy
    );

    // Arithmetic block side
    modport slave (
        input  in_valid, a, b, m, out_ready,
        output in_ready, out_valid, S, CoBo, busy
    );

endinterface
`default_nettype wire

// File: rtl/digit_serial_addsub_add2.sv
`default_nettype none
// ============================================================================
// Module   : digit_add2
// Brief    : Combinational 2-bit adder slice built from two full adders.
// Revision : 1.0 - initial release
// ============================================================================
module digit_add2
    import addsub_pkg::*;
(
    input  wire logic [c_DIGIT_W-1:0] a,
    input  wire logic [c_DIGIT_W-1:0] b,
    input  wire logic                 cin,
    output logic      [c_DIGIT_W-1:0] s,
    output logic                      cout
);

    logic w_c1;

    assign s[0]  = a[0] ^ b[0] ^ cin;
    assign w_c1  = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));

    assign s[1]  = a[1] ^ b[1] ^ w_c1;
    assign cout  = (a[1] & b[1]) | (w_c1 & (a[1] ^ b[1]));

endmodule
`default_nettype wire

// File: rtl/digit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : digit_serial_addsub
// Brief    : WIDTH-bit add/subtract processed two bits per clock, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module digit_serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    digit_serial_addsub_if.slave   bus
);

    localparam int              c_ND     = WIDTH / c_DIGIT_W;
    localparam int              c_KW     = (c_ND > 1) ? $clog2(c_ND) : 1;
    localparam logic [c_KW-1:0] c_K_LAST = c_KW'(c_ND - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [WIDTH-1:0]       r_a_sh;
    logic [WIDTH-1:0]       r_b_sh;
    logic [WIDTH-1:0]       r_s_sh;
    logic                   r_c;
    logic [c_KW-1:0]        r_k;
    logic [c_DIGIT_W-1:0]   w_d;
    logic                   w_cout;
    logic                   w_in_ready;
    logic                   w_accept;

    digit_add2 u_add2 (
        .a    (r_a_sh[c_DIGIT_W-1:0]),
        .b    (r_b_sh[c_DIGIT_W-1:0]),
        .cin  (r_c),
        .s    (w_d),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // DONE accepts new operands in the same edge the result is consumed
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (r_k == c_K_LAST) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_in_ready = bus.out_ready;
                if (bus.out_ready) begin
                    w_state_next = bus.in_valid ? RUN : IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_accept = bus.in_valid & w_in_ready;

    // Subtract is a + ~b + 1: invert b once on load and seed the carry with m
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_s_sh <= '0;
            r_c    <= 1'b0;
            r_k    <= '0;
        end else if (w_accept) begin
            r_a_sh <= bus.a;
            r_b_sh <= bus.b ^ {WIDTH{bus.m}};
            r_c    <= bus.m;
            r_k    <= '0;
        end else if (r_state == RUN) begin
            r_a_sh <= r_a_sh >> c_DIGIT_W;
            r_b_sh <= r_b_sh >> c_DIGIT_W;
            r_s_sh <= (r_s_sh >> c_DIGIT_W) | (WIDTH'(w_d) << (WIDTH - c_DIGIT_W));
            r_c    <= w_cout;
            r_k    <= r_k + c_KW'(1);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state == RUN);
    assign bus.S         = r_s_sh;
    assign bus.CoBo      = r_c;

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_digit_serial_addsub
// Brief    : Self-checking bench for WIDTH=8 and WIDTH=2 builds against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_digit_serial_addsub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    digit_serial_addsub_if #(.WIDTH(8)) bus8 ();
    digit_serial_addsub_if #(.WIDTH(2)) bus2 ();

    digit_serial_addsub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    digit_serial_addsub #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Reference: exact integer arithmetic, carry/no-borrow from comparison
    function automatic logic [8:0] model(input int w, input int ia, input int ib, input logic im);
        int mask = (1 << w) - 1;
        int r;
        logic co;
        if (!im) begin
            r  = ia + ib;
            co = (r > mask);
        end else begin
            r  = ia - ib;
            co = (ia >= ib);
        end
        return {co, 8'(r & mask)};
    endfunction

    // Drive one operation on the 8-bit DUT (which must be idle); returns result and latency
    task automatic run_op8(input logic [7:0] ia, input logic [7:0] ib, input logic im,
                           output logic [7:0] s, output logic co, output int lat);
        @(negedge clk);
        bus8.a = ia; bus8.b = ib; bus8.m = im; bus8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.m = 1'($urandom);
        lat = 0;
        while (!bus8.out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!bus8.out_valid) lat = -1;
        s  = bus8.S;
        co = bus8.CoBo;
        @(negedge clk);
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
    endtask

    task automatic run_op2(input logic [1:0] ia, input logic [1:0] ib, input logic im,
                           output logic [1:0] s, output logic co, output int lat);
        @(negedge clk);
        bus2.a = ia; bus2.b = ib; bus2.m = im; bus2.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
        bus2.a = 2'($urandom); bus2.b = 2'($urandom); bus2.m = 1'($urandom);
        lat = 0;
        while (!bus2.out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!bus2.out_valid) lat = -1;
        s  = bus2.S;
        co = bus2.CoBo;
        @(negedge clk);
        bus2.out_ready = 1'b1;
        @(posedge clk); #1;
        bus2.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        got = {bus8.in_ready, bus8.out_valid, bus8.busy, bus8.CoBo, bus8.S};
        n_cmp++;
        if (got !== 12'h800) begin
            n_err++;
            $display("FAIL reset_state: got {in_ready,out_valid,busy,CoBo,S}=%h want 800", got);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0] s;
        logic       co;
        int         lat;
        logic [7:0] ta [4] = '{8'h03, 8'h03, 8'h02, 8'hFF};
        logic [7:0] tb [4] = '{8'h01, 8'h01, 8'h03, 8'h01};
        logic       tm [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [8:0] want [4] = '{9'h004, 9'h102, 9'h0FF, 9'h100};
        for (int i = 0; i < 4; i++) begin
            run_op8(ta[i], tb[i], tm[i], s, co, lat);
            n_cmp++;
            if (lat !== 4) begin
                n_err++;
                $display("FAIL latency_%0d: got %0d edges want 4", i, lat);
            end
            n_cmp++;
            if ({co, s} !== want[i]) begin
                n_err++;
                $display("FAIL directed_%0d: got CoBo,S=%h want %h", i, {co, s}, want[i]);
            end
        end
    endtask

    task automatic test_busy();
        @(negedge clk);
        bus8.a = 8'h11; bus8.b = 8'h22; bus8.m = 1'b0; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        n_cmp++;
        if ({bus8.busy, bus8.in_ready, bus8.out_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL busy_in_run: got {busy,in_ready,out_valid}=%b want 100",
                     {bus8.busy, bus8.in_ready, bus8.out_valid});
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] s0;
        logic       c0;
        int         lat;
        int         bad;
        @(negedge clk);
        bus8.a = 8'hC8; bus8.b = 8'h64; bus8.m = 1'b1; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        s0 = bus8.S; c0 = bus8.CoBo;
        n_cmp++;
        if ({bus8.out_valid, c0, s0} !== {1'b1, 9'h164}) begin
            n_err++;
            $display("FAIL bp_first: got out_valid,CoBo,S=%b,%b,%h want 1,1,64", bus8.out_valid, c0, s0);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus8.S !== s0 || bus8.CoBo !== c0 || bus8.in_ready !== 1'b0 || bus8.out_valid !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end
        @(negedge clk);
        bus8.out_ready = 1'b1;
        bus8.a = 8'h10; bus8.b = 8'h20; bus8.m = 1'b0; bus8.in_valid = 1'b1;
        #1;
        n_cmp++;
        if (bus8.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_in_ready: got %b want 1", bus8.in_ready);
        end
        @(posedge clk); #1;
        bus8.out_ready = 1'b0; bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        n_cmp++;
        if (lat !== 4 || {bus8.CoBo, bus8.S} !== 9'h030) begin
            n_err++;
            $display("FAIL b2b_result: got lat=%0d CoBo,S=%h want lat=4 030", lat, {bus8.CoBo, bus8.S});
        end
        @(negedge clk);
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] s;
        logic       co;
        int         lat;
        @(negedge clk);
        bus8.a = 8'h7F; bus8.b = 8'h7F; bus8.m = 1'b0; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus8.in_ready, bus8.out_valid, bus8.busy, bus8.CoBo, bus8.S} !== 12'h800) begin
            n_err++;
            $display("FAIL reset_mid_run: got {in_ready,out_valid,busy,CoBo,S}=%h want 800",
                     {bus8.in_ready, bus8.out_valid, bus8.busy, bus8.CoBo, bus8.S});
        end
        @(negedge clk);
        rst = 1'b0;
        run_op8(8'h55, 8'hAA, 1'b0, s, co, lat);
        n_cmp++;
        if (lat !== 4 || {co, s} !== 9'h0FF) begin
            n_err++;
            $display("FAIL after_reset_op: got lat=%0d CoBo,S=%h want lat=4 0FF", lat, {co, s});
        end
    endtask

    task automatic test_random();
        logic [7:0] ia, ib, s;
        logic       im, co;
        logic [8:0] want;
        int         lat;
        for (int i = 0; i < 40; i++) begin
            ia = 8'($urandom); ib = 8'($urandom); im = 1'($urandom);
            want = model(8, int'(ia), int'(ib), im);
            run_op8(ia, ib, im, s, co, lat);
            n_cmp++;
            if (lat !== 4 || {co, s} !== want) begin
                n_err++;
                $display("FAIL random_%0d: a=%h b=%h m=%b got lat=%0d CoBo,S=%h want lat=4 %h",
                         i, ia, ib, im, lat, {co, s}, want);
            end
        end
    endtask

    task automatic test_width2();
        logic [1:0] s;
        logic       co;
        int         lat;
        logic [8:0] want;
        run_op2(2'b11, 2'b11, 1'b0, s, co, lat);
        n_cmp++;
        if (lat !== 1 || {co, s} !== 3'b110) begin
            n_err++;
            $display("FAIL w2_add: got lat=%0d CoBo,S=%b want lat=1 110", lat, {co, s});
        end
        run_op2(2'b10, 2'b11, 1'b1, s, co, lat);
        n_cmp++;
        if (lat !== 1 || {co, s} !== 3'b011) begin
            n_err++;
            $display("FAIL w2_sub: got lat=%0d CoBo,S=%b want lat=1 011", lat, {co, s});
        end
        for (int x = 0; x < 32; x++) begin
            want = model(2, x & 3, (x >> 2) & 3, 1'(x >> 4));
            run_op2(2'(x), 2'(x >> 2), 1'(x >> 4), s, co, lat);
            n_cmp++;
            if (lat !== 1 || {co, s} !== {want[8], want[1:0]}) begin
                n_err++;
                $display("FAIL w2_exh_%0d: got lat=%0d CoBo,S=%b want lat=1 %b",
                         x, lat, {co, s}, {want[8], want[1:0]});
            end
        end
    endtask

    initial begin
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
        bus8.a = '0; bus8.b = '0; bus8.m = 1'b0;
        bus2.in_valid = 1'b0; bus2.out_ready = 1'b0;
        bus2.a = '0; bus2.b = '0; bus2.m = 1'b0;
        test_reset();
        test_directed();
        test_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        test_width2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
